// File: rtl/mem_bist_pkg.sv
// rtl/mem_bist_pkg.sv - March C- BIST shared constants: FSM states, element codes, element table
package mem_bist_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] ELEM_E0 = 3'd0;
    localparam logic [2:0] ELEM_E1 = 3'd1;
    localparam logic [2:0] ELEM_E2 = 3'd2;
    localparam logic [2:0] ELEM_E3 = 3'd3;
    localparam logic [2:0] ELEM_E4 = 3'd4;
    localparam logic [2:0] ELEM_E5 = 3'd5;

    // One March element: address direction and the read/write operations per address.
    // rd_val/wr_val select the background: 0 = PATTERN, 1 = ~PATTERN.
    typedef struct packed {
        logic down;
        logic has_rd;
        logic rd_val;
        logic has_wr;
        logic wr_val;
    } elem_t;

    // Indexed by element code. Bit order per entry: {down, has_rd, rd_val, has_wr, wr_val}.
    // Codes 6 and 7 never occur; they are zero so the table can be indexed by any 3-bit value.
    localparam elem_t [7:0] ELEM_TABLE = {
        5'b00000,   // 7 unused
        5'b00000,   // 6 unused
        5'b01000,   // E5 u(r0)
        5'b11110,   // E4 d(r1,w0)
        5'b11011,   // E3 d(r0,w1)
        5'b01110,   // E2 u(r1,w0)
        5'b01011,   // E1 u(r0,w1)
        5'b00010    // E0 u(w0)
    };

endpackage

// File: rtl/mem_bist_cmp.sv
// rtl/mem_bist_cmp.sv - read-compare pipeline, saturating error counter, first-failure capture
//
// Ports:
//   clk, arst_n              clock, asynchronous active-low reset
//   clear                    zero the counter and capture registers (accepted start)
//   rd_en/rd_addr/rd_elem    read issued this cycle and its address / March element
//   rd_exp                   value the issued read must return
//   rd_data                  memory data, valid the cycle after rd_en
//   err_count                saturating mismatch count
//   fail_addr/elem/syndrome  first mismatch diagnostics, held until clear
//   any_err                  a mismatch has been counted or is being counted this cycle
module mem_bist_cmp #(
    parameter int ABITS = 8,
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             clear,
    input  logic             rd_en,
    input  logic [ABITS-1:0] rd_addr,
    input  logic [2:0]       rd_elem,
    input  logic [WIDTH-1:0] rd_exp,
    input  logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] err_count,
    output logic [ABITS-1:0] fail_addr,
    output logic [2:0]       fail_elem,
    output logic [WIDTH-1:0] fail_syndrome,
    output logic             any_err
);

    logic             p_valid;
    logic [ABITS-1:0] p_addr;
    logic [2:0]       p_elem;
    logic [WIDTH-1:0] p_exp;
    logic [WIDTH-1:0] syndrome;
    logic             mismatch;

    assign syndrome = rd_data ^ p_exp;
    assign mismatch = p_valid && (syndrome != '0);
    // Includes the compare in flight so the final DRAIN compare is reflected in pass.
    assign any_err  = (err_count != '0) || mismatch;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            p_valid       <= 1'b0;
            p_addr        <= '0;
            p_elem        <= '0;
            p_exp         <= '0;
            err_count     <= '0;
            fail_addr     <= '0;
            fail_elem     <= '0;
            fail_syndrome <= '0;
        end else begin
            p_valid <= rd_en;
            if (rd_en) begin
                p_addr <= rd_addr;
                p_elem <= rd_elem;
                p_exp  <= rd_exp;
            end
            if (clear) begin
                err_count     <= '0;
                fail_addr     <= '0;
                fail_elem     <= '0;
                fail_syndrome <= '0;
            end else if (mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + CNT_W'(1);
                end
                // A zero count means nothing has been captured since the last clear.
                if (err_count == '0) begin
                    fail_addr     <= p_addr;
                    fail_elem     <= p_elem;
                    fail_syndrome <= syndrome;
                end
            end
        end
    end

endmodule

// File: rtl/mem_march_bist.sv
// rtl/mem_march_bist.sv - March C- memory BIST controller driving one read and one write port
//
// Ports:
//   clk, arst_n                 clock, asynchronous active-low reset
//   start                       begin a test (sampled in IDLE only)
//   busy, done, pass            status: running, one-cycle completion, no-mismatch result
//   err_count, fail_*           mismatch count and first-mismatch diagnostics
//   mem_rd_en/addr/data         memory read port (data one cycle after enable)
//   mem_wr_en/addr/data/be      memory write port (byte enables always all-ones)
module mem_march_bist
    import mem_bist_pkg::*;
#(
    parameter int               SIZE    = 256,
    parameter int               ABITS   = 8,
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] PATTERN = '0,
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [ABITS-1:0] fail_addr,
    output logic [2:0]       fail_elem,
    output logic [WIDTH-1:0] fail_syndrome,
    output logic             mem_rd_en,
    output logic [ABITS-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0] mem_rd_data,
    output logic             mem_wr_en,
    output logic [ABITS-1:0] mem_wr_addr,
    output logic [WIDTH-1:0] mem_wr_data,
    output logic [WIDTH-1:0] mem_wr_be
);

    localparam logic [ABITS-1:0] LAST_ADDR = ABITS'(SIZE - 1);

    logic [1:0]       state;
    logic [2:0]       elem;
    logic [ABITS-1:0] addr;
    logic             phase;     // 0 = read slot, 1 = write slot of a read-write element
    elem_t            cur;
    logic             run;
    logic             last_op;
    logic             at_end;
    logic             next_down;
    logic             any_err;
    logic [WIDTH-1:0] rd_exp;

    assign cur       = ELEM_TABLE[elem];
    assign next_down = ELEM_TABLE[elem + 3'd1].down;
    assign run       = (state == ST_RUN);
    assign last_op   = !(cur.has_rd && cur.has_wr) || phase;
    assign at_end    = cur.down ? (addr == '0) : (addr == LAST_ADDR);

    // All port outputs decode from registered state, so a reset drops them at once.
    assign busy        = run || (state == ST_DRAIN);
    assign done        = (state == ST_DONE);
    assign mem_rd_en   = run && cur.has_rd && !phase;
    assign mem_wr_en   = run && cur.has_wr && (phase || !cur.has_rd);
    assign mem_rd_addr = addr;
    assign mem_wr_addr = addr;
    assign mem_wr_data = cur.wr_val ? ~PATTERN : PATTERN;
    assign mem_wr_be   = '1;
    assign rd_exp      = cur.rd_val ? ~PATTERN : PATTERN;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_IDLE;
            elem  <= ELEM_E0;
            addr  <= '0;
            phase <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        elem  <= ELEM_E0;
                        addr  <= '0;
                        phase <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!last_op) begin
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (!at_end) begin
                            addr <= cur.down ? addr - ABITS'(1) : addr + ABITS'(1);
                        end else if (elem == ELEM_E5) begin
                            state <= ST_DRAIN;
                        end else begin
                            // Next element starts immediately, from its own end of the range.
                            elem <= elem + 3'd1;
                            addr <= next_down ? LAST_ADDR : '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                    pass  <= !any_err;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_bist_cmp #(
        .ABITS (ABITS),
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cmp (
        .clk           (clk),
        .arst_n        (arst_n),
        .clear         ((state == ST_IDLE) && start),
        .rd_en         (mem_rd_en),
        .rd_addr       (addr),
        .rd_elem       (elem),
        .rd_exp        (rd_exp),
        .rd_data       (mem_rd_data),
        .err_count     (err_count),
        .fail_addr     (fail_addr),
        .fail_elem     (fail_elem),
        .fail_syndrome (fail_syndrome),
        .any_err       (any_err)
    );

endmodule

// File: tb/tb_mem_march_bist.sv
// tb/tb_mem_march_bist.sv - self-checking bench for mem_march_bist
module tb_mem_march_bist;

    localparam logic [31:0] PAT_A = 32'h0000_0000;
    localparam logic [31:0] PAT_B = 32'hA5A5_0F0F;
    localparam logic [31:0] PAT_C = 32'h1234_5678;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n;
    logic        start [3];
    logic        busy [3], done [3], pass [3], rd_en [3], wr_en [3];
    logic [15:0] errc [3];
    logic [7:0]  faddr [3], rda [3], wra [3];
    logic [2:0]  felem [3];
    logic [31:0] fsyn [3], wrd [3], be [3], rdd [3];

    logic [3:0]  errc_a, faddr_a, rda_a, wra_a;
    logic [15:0] errc_b, errc_c;
    logic [3:0]  faddr_b, rda_b, wra_b;
    logic [0:0]  faddr_c, rda_c, wra_c;

    assign errc[0] = {12'd0, errc_a};  assign faddr[0] = {4'd0, faddr_a};
    assign rda[0]  = {4'd0, rda_a};    assign wra[0]   = {4'd0, wra_a};
    assign errc[1] = errc_b;           assign faddr[1] = {4'd0, faddr_b};
    assign rda[1]  = {4'd0, rda_b};    assign wra[1]   = {4'd0, wra_b};
    assign errc[2] = errc_c;           assign faddr[2] = {7'd0, faddr_c};
    assign rda[2]  = {7'd0, rda_c};    assign wra[2]   = {7'd0, wra_c};

    mem_march_bist #(.SIZE(16), .ABITS(4), .WIDTH(32), .PATTERN(PAT_A), .CNT_W(4)) dut_a (
        .clk(clk), .arst_n(arst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(errc_a), .fail_addr(faddr_a), .fail_elem(felem[0]),
        .fail_syndrome(fsyn[0]), .mem_rd_en(rd_en[0]), .mem_rd_addr(rda_a),
        .mem_rd_data(rdd[0]), .mem_wr_en(wr_en[0]), .mem_wr_addr(wra_a),
        .mem_wr_data(wrd[0]), .mem_wr_be(be[0]));

    mem_march_bist #(.SIZE(10), .ABITS(4), .WIDTH(32), .PATTERN(PAT_B), .CNT_W(16)) dut_b (
        .clk(clk), .arst_n(arst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(errc_b), .fail_addr(faddr_b), .fail_elem(felem[1]),
        .fail_syndrome(fsyn[1]), .mem_rd_en(rd_en[1]), .mem_rd_addr(rda_b),
        .mem_rd_data(rdd[1]), .mem_wr_en(wr_en[1]), .mem_wr_addr(wra_b),
        .mem_wr_data(wrd[1]), .mem_wr_be(be[1]));

    mem_march_bist #(.SIZE(1), .ABITS(1), .WIDTH(32), .PATTERN(PAT_C), .CNT_W(16)) dut_c (
        .clk(clk), .arst_n(arst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .err_count(errc_c), .fail_addr(faddr_c), .fail_elem(felem[2]),
        .fail_syndrome(fsyn[2]), .mem_rd_en(rd_en[2]), .mem_rd_addr(rda_c),
        .mem_rd_data(rdd[2]), .mem_wr_en(wr_en[2]), .mem_wr_addr(wra_c),
        .mem_wr_data(wrd[2]), .mem_wr_be(be[2]));

    // Fault injection: kind 0 none, 1 stuck bit on one word, 2 every read inverted.
    int sel, f_kind, f_addr, f_bit, f_val;

    function automatic logic [31:0] fault_wr(input int i, input int a, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (i == sel && f_kind == 1 && a == f_addr) r[f_bit] = f_val[0];
        return r;
    endfunction

    // Ideal single-cycle memories, one per instance, with the fault applied on write/read.
    logic [31:0] mem [3][16];
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (wr_en[i]) mem[i][wra[i][3:0]] <= fault_wr(i, int'(wra[i]), wrd[i]);
            if (rd_en[i]) rdd[i] <= (i == sel && f_kind == 2) ? ~mem[i][rda[i][3:0]]
                                                              : mem[i][rda[i][3:0]];
        end
    end

    function automatic int size_of(input int i);
        return (i == 0) ? 16 : (i == 1) ? 10 : 1;
    endfunction
    function automatic logic [31:0] pat_of(input int i);
        return (i == 0) ? PAT_A : (i == 1) ? PAT_B : PAT_C;
    endfunction
    function automatic int cnt_max(input int i);
        return (i == 0) ? 15 : 65535;
    endfunction

    // Reference model: expands the March C- description into a per-cycle operation list
    // and plays it against an array memory with the same fault to predict the verdict.
    typedef struct {bit rd; bit wr; int addr; logic [31:0] wd;} op_t;
    op_t q[$];
    int          m_err, m_elem, m_addr;
    logic [31:0] m_syn;
    bit          m_pass;
    int E_DOWN [6] = '{0, 0, 0, 1, 1, 0};
    int E_RD   [6] = '{-1, 0, 1, 0, 1, 0};   // -1: no read, else background value read
    int E_WR   [6] = '{0, 1, 0, 1, 0, -1};   // -1: no write, else background value written

    task automatic model_run(input int i);
        int n, a;
        logic [31:0] p, got, ev;
        logic [31:0] m [16];
        n = size_of(i); p = pat_of(i);
        q.delete(); m_err = 0; m_elem = 0; m_addr = 0; m_syn = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < n; k++) begin
                a = (E_DOWN[e] != 0) ? n - 1 - k : k;
                if (E_RD[e] >= 0) begin
                    q.push_back('{1'b1, 1'b0, a, 32'd0});
                    got = (i == sel && f_kind == 2) ? ~m[a] : m[a];
                    ev  = (E_RD[e] != 0) ? ~p : p;
                    if (got !== ev) begin
                        if (m_err == 0) begin m_elem = e; m_addr = a; m_syn = got ^ ev; end
                        if (m_err < cnt_max(i)) m_err++;
                    end
                end
                if (E_WR[e] >= 0) begin
                    ev = (E_WR[e] != 0) ? ~p : p;
                    q.push_back('{1'b0, 1'b1, a, ev});
                    m[a] = fault_wr(i, a, ev);
                end
            end
        end
        m_pass = (m_err == 0);
    endtask

    int n_err = 0, n_chk = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int inst; int kind; int fa; int fb; int fv;
        bit pass; int err; int elem; int addr; logic [31:0] syn;
    } vec_t;
    vec_t vt [6];
    vec_t vz;

    // One complete test run. Samples every cycle at the falling edge; cycle 1 is the
    // cycle after the start edge. Expected verdict from the table or from the model.
    task automatic run_one(input int i, input bit use_tab, input vec_t v,
                           input int pulse_at, input bit hold_end, input bit pre_started);
        int n, bad_busy, bad_done, bad_op, bad_clr, maxa;
        op_t op;
        n = size_of(i);
        model_run(i);
        bad_busy = 0; bad_done = 0; bad_op = 0; bad_clr = 0; maxa = 0;
        if (!pre_started) begin
            @(negedge clk) start[i] = 1'b1;
        end
        @(negedge clk) start[i] = 1'b0;
        for (int cyc = 1; cyc <= 10 * n + 2; cyc++) begin
            if (busy[i] !== (cyc <= 10 * n + 1)) bad_busy++;
            if (done[i] !== (cyc == 10 * n + 2)) bad_done++;
            if (cyc <= 10 * n + 1 && pass[i] !== 1'b0) bad_clr++;
            if (cyc == 1 && (errc[i] != 0 || faddr[i] != 0 || felem[i] != 0 || fsyn[i] != 0))
                bad_clr++;
            if (be[i] !== 32'hFFFF_FFFF) bad_op++;
            if (cyc <= 10 * n) begin
                op = q[cyc - 1];
                if (rd_en[i] !== op.rd || wr_en[i] !== op.wr || int'(rda[i]) != op.addr ||
                    int'(wra[i]) != op.addr || (op.wr && wrd[i] !== op.wd)) bad_op++;
                if (int'(rda[i]) > maxa) maxa = int'(rda[i]);
            end else if (rd_en[i] !== 1'b0 || wr_en[i] !== 1'b0) begin
                bad_op++;
            end
            if (cyc == 10 * n + 2) begin
                chk($sformatf("pass[%0d]", i), pass[i], use_tab ? v.pass : m_pass);
                chk($sformatf("err_count[%0d]", i), errc[i], use_tab ? v.err : m_err);
                chk($sformatf("fail_elem[%0d]", i), felem[i], use_tab ? v.elem : m_elem);
                chk($sformatf("fail_addr[%0d]", i), faddr[i], use_tab ? v.addr : m_addr);
                chk($sformatf("fail_syndrome[%0d]", i), fsyn[i], use_tab ? v.syn : m_syn);
            end
            start[i] = (cyc == pulse_at) || (hold_end && cyc == 10 * n + 2);
            @(negedge clk);
        end
        chk($sformatf("busy_window[%0d]", i), bad_busy, 0);
        chk($sformatf("done_pulse[%0d]", i), bad_done, 0);
        chk($sformatf("op_trace[%0d]", i), bad_op, 0);
        chk($sformatf("start_clear[%0d]", i), bad_clr, 0);
        chk($sformatf("max_addr[%0d]", i), maxa, n - 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{0, 0, 0, 0, 0, 1'b1, 0,  0, 0, 32'h0000_0000};
        vt[1] = '{0, 1, 5, 3, 0, 1'b0, 2,  2, 5, 32'h0000_0008};
        vt[2] = '{0, 2, 0, 0, 0, 1'b0, 15, 1, 0, 32'hFFFF_FFFF};
        vt[3] = '{1, 0, 0, 0, 0, 1'b1, 0,  0, 0, 32'h0000_0000};
        vt[4] = '{2, 0, 0, 0, 0, 1'b1, 0,  0, 0, 32'h0000_0000};
        vt[5] = '{2, 1, 0, 0, 1, 1'b0, 3,  1, 0, 32'h0000_0001};
        vz    = '{0, 0, 0, 0, 0, 1'b0, 0,  0, 0, 32'h0};

        arst_n = 1'b0; sel = 0; f_kind = 0; f_addr = 0; f_bit = 0; f_val = 0;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_ctl[%0d]", i), {busy[i], done[i], pass[i], rd_en[i], wr_en[i]}, 0);
            chk($sformatf("reset_diag[%0d]", i), errc[i] | faddr[i] | felem[i] | fsyn[i], 0);
        end
        arst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            sel = vt[k].inst; f_kind = vt[k].kind;
            f_addr = vt[k].fa; f_bit = vt[k].fb; f_val = vt[k].fv;
            run_one(vt[k].inst, 1'b1, vt[k], 0, 1'b0, 1'b0);
        end

        for (int r = 0; r < 8; r++) begin
            int i;
            i = int'($urandom_range(2));
            sel = i; f_kind = int'($urandom_range(2));
            f_addr = int'($urandom_range(size_of(i) - 1));
            f_bit = int'($urandom_range(31)); f_val = int'($urandom_range(1));
            run_one(i, 1'b0, vz, 0, 1'b0, 1'b0);
        end

        // Start pulsed mid-run is ignored; start held through DONE launches a fresh,
        // cleared run right after.
        sel = 0; f_kind = 1; f_addr = 5; f_bit = 3; f_val = 0;
        run_one(0, 1'b1, vt[1], 30, 1'b1, 1'b0);
        f_kind = 0;
        run_one(0, 1'b0, vz, 0, 1'b0, 1'b1);

        // Asynchronous reset in cycle 50 of a run.
        sel = 0; f_kind = 0;
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        repeat (49) @(negedge clk);
        chk("pre_reset_active", rd_en[0] | wr_en[0], 1);
        arst_n = 1'b0;
        #1;
        chk("async_drop", {busy[0], rd_en[0], wr_en[0]}, 0);
        @(negedge clk) arst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ctl", {busy[0], done[0], pass[0], rd_en[0], wr_en[0]}, 0);
        chk("post_reset_diag", errc[0] | faddr[0] | felem[0] | fsyn[0], 0);
        run_one(0, 1'b1, vt[0], 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
